secure_mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing the single-port secure key/ID memory (256-bit × 16) between up to NUM_REQ requesters inside the MCSE control unit. Requesters: 0 = secure boot control, 1 = lifecycle protection, 2 = spare/debug.
- Serialises one transaction at a time and drives the memory's rd_en/wr_en/addr/wrData strobes.
- Enforces per-entry write locks, where only requester 0 may write a locked entry.
- Bounds read latency with a timeout.

---
 rtl/secure_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_secure_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secure_mem_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port secure key/ID memory.
// Define SECURE_MEM_ARB_AUDIT_EN to add the violation counter and sticky irq outputs.
module secure_mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 256,
  parameter int LENGTH  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*$clog2(LENGTH)-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]           req_wdata,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic                               rsp_err,
  output logic [WIDTH-1:0]                   rsp_rdata,
  input  logic [LENGTH-1:0]                  wr_lock,
  output logic                               mem_rd_en,
  output logic                               mem_wr_en,
  output logic [$clog2(LENGTH)-1:0]          mem_addr,
  output logic [WIDTH-1:0]                   mem_wrData,
  input  logic [WIDTH-1:0]                   mem_rdData,
`ifdef SECURE_MEM_ARB_AUDIT_EN
  output logic [7:0]                         violation_count,
  output logic                               violation_irq,
`endif
  input  logic                               mem_rdData_valid
);

  localparam int AW = $clog2(LENGTH);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;

  logic [GW-1:0]     sel;
  logic              found;
  logic              lock_hit;

  // First requesting index after the last grant, wrapping.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      automatic int idx = (int'(last_q) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && state_q == IDLE && found)
      req_ready[sel] = 1'b1;
  end

  assign lock_hit = wr_lock[addr_q] && (grant_q != '0);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          grant_d = sel;
          wr_d    = req_write[sel];
          addr_d  = req_addr[sel*AW +: AW];
          wdata_d = req_wdata[sel*WIDTH +: WIDTH];
        end
      end
      ISSUE: begin
        tcnt_d  = '0;
        rdata_d = '0;
        err_d   = wr_q && lock_hit;
        state_d = wr_q ? RESP : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_rdData_valid) begin
          rdata_d = mem_rdData;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes are decoded from registered state so reset drops them at once.
  assign mem_wr_en  = (state_q == ISSUE) && wr_q && !lock_hit;
  assign mem_rd_en  = (state_q == ISSUE) && !wr_q;
  assign mem_addr   = (mem_wr_en || mem_rd_en) ? addr_q : '0;
  assign mem_wrData = mem_wr_en ? wdata_q : '0;

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP)
      rsp_valid[grant_q] = 1'b1;
  end

  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;

`ifdef SECURE_MEM_ARB_AUDIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      violation_count <= '0;
      violation_irq   <= 1'b0;
    end else if (state_q == RESP && err_q) begin
      violation_irq <= 1'b1;
      if (violation_count != 8'hFF)
        violation_count <= violation_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_secure_mem_arbiter.sv
// Bench for secure_mem_arbiter: vector table, round-robin, lock, timeout and reset sequences.
// Accepted requests push expectations; the monitor pops and compares on rsp_valid.
module tb_secure_mem_arbiter;

  localparam int NR = 3;
  localparam int W  = 256;
  localparam int L  = 16;
  localparam int AW = 4;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*W-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic            rsp_err;
  logic [W-1:0]    rsp_rdata;
  logic [L-1:0]    wr_lock = '0;
  logic            mem_rd_en;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [W-1:0]    mem_wrData;
  logic [W-1:0]    mem_rdData = '0;
  logic            mem_rdData_valid = 1'b0;
`ifdef SECURE_MEM_ARB_AUDIT_EN
  logic [7:0]      violation_count;
  logic            violation_irq;
`endif

  secure_mem_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .LENGTH(L), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .wr_lock(wr_lock),
    .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr),
    .mem_wrData(mem_wrData),
    .mem_rdData(mem_rdData),
`ifdef SECURE_MEM_ARB_AUDIT_EN
    .violation_count(violation_count),
    .violation_irq(violation_irq),
`endif
    .mem_rdData_valid(mem_rdData_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         req;
    logic [W-1:0] rdata;
    logic       err;
    int         acc;
    int         lat;
    int         wr;
  } sb_t;

  typedef struct {
    logic       err;
    logic [W-1:0] rdata;
    int         lat;
    int         wr;
  } exp_t;

  typedef struct {
    int         req;
    bit         wr;
    int         addr;
    logic [W-1:0] wdata;
    logic [L-1:0] lock;
    int         delay;
    logic       exp_err;
    logic [W-1:0] exp_rdata;
    int         exp_lat;
    int         exp_wr;
  } vec_t;

  sb_t   sb[$];
  int    grant_log[$];
  exp_t  exp_by_req [NR];
  logic [W-1:0] bmem [L];
  int    tests = 0;
  int    failed = 0;
  int    cyc = 0;
  int    rd_cnt = -1;
  int    rd_delay = -1;
  int    wr_cnt = 0;
  bit    accepted = 0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model, scoreboard push on accept, pop on response.
  always @(negedge clk) begin
    if (!rst) begin
      rd_cnt = -1;
      mem_rdData_valid = 1'b0;
    end else begin
      if (mem_wr_en) begin
        bmem[mem_addr] = mem_wrData;
        wr_cnt++;
      end
      if (rd_cnt > 0) begin
        rd_cnt--;
        mem_rdData_valid = (rd_cnt == 0);
      end else begin
        mem_rdData_valid = 1'b0;
      end
      if (mem_rd_en) begin
        mem_rdData = bmem[mem_addr];
        rd_cnt = rd_delay;
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_rsp: got rsp_valid %b required none", rsp_valid);
        end else begin
          automatic sb_t e = sb.pop_front();
          automatic logic [NR-1:0] oh = '0;
          oh[e.req] = 1'b1;
          check("rsp_onehot", rsp_valid, oh);
          check("rsp_err", rsp_err, e.err);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_latency", cyc - e.acc, e.lat);
          check("wr_strobes", wr_cnt, e.wr);
        end
      end
      if ((req_valid & req_ready) != '0) begin
        automatic int g = 0;
        automatic sb_t s;
        for (int i = 0; i < NR; i++)
          if (req_valid[i] && req_ready[i]) g = i;
        s.req   = g;
        s.err   = exp_by_req[g].err;
        s.rdata = exp_by_req[g].rdata;
        s.acc   = cyc;
        s.lat   = exp_by_req[g].lat;
        s.wr    = exp_by_req[g].wr;
        sb.push_back(s);
        grant_log.push_back(g);
        accepted = 1;
        wr_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      step();
      n++;
    end
    if (sb.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL %s: got %0d pending responses required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic set_req(input int r, input bit wr, input int addr,
                         input logic [W-1:0] data);
    req_write[r]          = wr;
    req_addr[r*AW +: AW]  = AW'(addr);
    req_wdata[r*W +: W]   = data;
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0;
    step();
    wr_lock  = v.lock;
    rd_delay = v.delay;
    set_req(v.req, v.wr, v.addr, v.wdata);
    exp_by_req[v.req].err   = v.exp_err;
    exp_by_req[v.req].rdata = v.exp_rdata;
    exp_by_req[v.req].lat   = v.exp_lat;
    exp_by_req[v.req].wr    = v.exp_wr;
    accepted  = 0;
    req_valid = '0;
    req_valid[v.req] = 1'b1;
    while (!accepted && n < 20) begin
      step();
      n++;
    end
    req_valid = '0;
    if (!accepted) begin
      tests++;
      failed++;
      $display("FAIL accept_timeout: got no grant for req %0d required grant", v.req);
    end
    drain("vec_drain");
  endtask

  task automatic wait_grants(input int cnt, input string name);
    int n = 0;
    while (grant_log.size() < cnt && n < 40) begin
      step();
      n++;
    end
    check(name, grant_log.size(), cnt);
  endtask

  vec_t vecs [9];
  logic [W-1:0] pa5, p5a, p3c, p11;
  int n_err;

  initial begin
    pa5 = {32{8'hA5}};
    p5a = {32{8'h5A}};
    p3c = {32{8'h3C}};
    p11 = {32{8'h11}};
    for (int i = 0; i < L; i++) bmem[i] = '0;
    vecs[0] = '{0, 1, 3, pa5, 16'h0000, -1, 1'b0, '0,  2, 1};
    vecs[1] = '{1, 0, 3, '0,  16'h0000,  2, 1'b0, pa5, 4, 0};
    vecs[2] = '{1, 1, 5, p5a, 16'h0020, -1, 1'b1, '0,  2, 0};
    vecs[3] = '{2, 0, 5, '0,  16'h0020,  1, 1'b0, '0,  3, 0};
    vecs[4] = '{0, 1, 5, p3c, 16'h0020, -1, 1'b0, '0,  2, 1};
    vecs[5] = '{2, 0, 5, '0,  16'h0020,  1, 1'b0, p3c, 3, 0};
    vecs[6] = '{2, 0, 7, '0,  16'h0000, -1, 1'b1, '0, TO + 2, 0};
    vecs[7] = '{1, 0, 3, '0,  16'h0000, TO, 1'b0, pa5, TO + 2, 0};
    vecs[8] = '{0, 0, 5, '0,  16'h0000, TO + 1, 1'b1, '0, TO + 2, 0};

    // Outputs quiet while held in reset, even with requests pending.
    req_valid = '1;
    #12;
    check("reset_ready", req_ready, '0);
    check("reset_rsp_valid", rsp_valid, '0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, '0);
    check("reset_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
    check("reset_mem_addr", mem_addr, '0);
    check("reset_mem_wrData", mem_wrData, '0);
`ifdef SECURE_MEM_ARB_AUDIT_EN
    check("reset_viol_count", violation_count, 8'd0);
    check("reset_viol_irq", violation_irq, 1'b0);
`endif
    req_valid = '0;
    #10;
    rst = 1'b1;

    // All requesters held high: fair rotation starting at 0.
    step();
    for (int r = 0; r < NR; r++) begin
      set_req(r, 1'b1, (r == 2) ? 4 : r + 1, p11);
      exp_by_req[r] = '{1'b0, '0, 2, 1};
    end
    grant_log.delete();
    req_valid = '1;
    wait_grants(6, "rr_grant_count");
    req_valid = '0;
    drain("rr_drain");
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size())
        check($sformatf("rr_order_%0d", i), grant_log[i], i % NR);

    n_err = 0;
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
      n_err += int'(vecs[i].exp_err);
    end
`ifdef SECURE_MEM_ARB_AUDIT_EN
    check("viol_count", violation_count, n_err);
    check("viol_irq", violation_irq, 1'b1);
`endif

    // Reset while waiting for read data, then 0 beats 2 on re-arbitration.
    step();
    rd_delay = -1;
    set_req(1, 1'b0, 3, '0);
    exp_by_req[1] = '{1'b0, '0, 2, 0};
    accepted  = 0;
    req_valid = 3'b010;
    for (int n = 0; n < 20 && !accepted; n++) step();
    req_valid = '0;
    step();
    step();
    set_req(0, 1'b1, 8, p11);
    set_req(2, 1'b1, 9, p5a);
    exp_by_req[0] = '{1'b0, '0, 2, 1};
    exp_by_req[2] = '{1'b0, '0, 2, 1};
    req_valid = 3'b101;
    rst = 1'b0;
    #1;
    sb.delete();
    grant_log.delete();
    check("midrst_ready", req_ready, '0);
    check("midrst_rsp_valid", rsp_valid, '0);
    check("midrst_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
    step();
    #2;
    rst = 1'b1;
    wait_grants(1, "midrst_first_grant");
    req_valid[0] = 1'b0;
    wait_grants(2, "midrst_second_grant");
    req_valid = '0;
    drain("midrst_drain");
    if (grant_log.size() >= 2) begin
      check("midrst_grant0", grant_log[0], 0);
      check("midrst_grant1", grant_log[1], 2);
    end
    check("mem_addr8", bmem[8], p11);
    check("mem_addr9", bmem[9], p5a);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
